// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the CPU/DMA bus arbiter.
// Also used by later IO arbitration blocks.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ARB_PARK,
    ARB_TURN,
    ARB_GRANT
  } arb_state_e;

  localparam int CPU_ID  = 0;
  localparam int DMA1_ID = 1;
  localparam int DMA2_ID = 2;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request
// at or after the pointer, wrapping modulo N.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int N = 3,
  parameter int W = id_w(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_win,
  output logic         o_valid
);

  int w_idx;

  always_comb begin
    o_win   = '0;
    o_valid = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(i_ptr) + k) % N;
      if (!o_valid && i_req[w_idx]) begin
        o_valid = 1'b1;
        o_win   = W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shared bus arbiter: parks on PARK_ID, round-robin for the
// rest, one-cycle turnaround between drivers, hold limit.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int PARK_ID  = CPU_ID,
  parameter int MAX_HOLD = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_REQ-1:0]          REQ,
  input  logic [N_REQ-1:0]          DONE,
  output logic [N_REQ-1:0]          GNT,
  output logic [id_w(N_REQ)-1:0]    GNT_ID,
  output logic                      ADE,
  output logic                      BUS_BUSY,
  output logic                      TIMEOUT
);

  localparam int W = id_w(N_REQ);
  localparam logic [W-1:0] PARK_W = W'(PARK_ID);
  localparam logic [W-1:0] PNEXT_W =
    W'((PARK_ID + 1) % N_REQ);
  localparam logic [7:0] MAXH = 8'(MAX_HOLD);
  localparam logic [N_REQ-1:0] PARK_OH =
    {{(N_REQ-1){1'b0}}, 1'b1} << PARK_ID;

  arb_state_e       r_state;
  logic [W-1:0]     r_win;
  logic [W-1:0]     r_ptr;
  logic [7:0]       r_cnt;
  logic             r_to_park;

  logic [N_REQ-1:0] w_own_mask;
  logic [N_REQ-1:0] w_win_mask;
  logic [N_REQ-1:0] w_others;
  logic [N_REQ-1:0] w_pick_req;
  logic             w_oth_any;
  logic             w_end;
  logic [7:0]       w_cnt_nxt;
  logic [W-1:0]     w_pw;
  logic             w_pv;
  logic [W-1:0]     w_win_inc;

  always_comb begin
    w_own_mask = '0;
    w_win_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_own_mask[i] = (GNT_ID == W'(i));
      w_win_mask[i] = (r_win == W'(i));
    end
    w_others   = REQ & ~w_own_mask;
    w_oth_any  = |w_others;
    w_pick_req = (r_state == ARB_GRANT) ? w_others : REQ;
    // a timeout flag raised last cycle revokes now
    w_end      = |(DONE & w_own_mask)
               | ~|(REQ & w_own_mask)
               | TIMEOUT;
    w_cnt_nxt  = (r_cnt == MAXH) ? r_cnt : r_cnt + 8'd1;
    w_win_inc  = (r_win == W'(N_REQ - 1)) ? '0
                                          : r_win + W'(1);
  end

  rr_pick #(
    .N (N_REQ),
    .W (W)
  ) u_pick (
    .i_req   (w_pick_req),
    .i_ptr   (r_ptr),
    .o_win   (w_pw),
    .o_valid (w_pv)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ARB_PARK;
      GNT       <= PARK_OH;
      GNT_ID    <= PARK_W;
      ADE       <= 1'b0;
      BUS_BUSY  <= 1'b0;
      TIMEOUT   <= 1'b0;
      r_cnt     <= '0;
      r_ptr     <= PNEXT_W;
      r_win     <= PARK_W;
      r_to_park <= 1'b0;
    end else begin
      TIMEOUT <= 1'b0;
      unique case (r_state)
        ARB_PARK: begin
          if (REQ[PARK_ID]) begin
            r_state  <= ARB_GRANT;
            GNT      <= PARK_OH;
            GNT_ID   <= PARK_W;
            ADE      <= 1'b0;
            BUS_BUSY <= 1'b1;
            r_cnt    <= 8'd1;
            r_ptr    <= PNEXT_W;
            TIMEOUT  <= (MAXH == 8'd1) && |(REQ & ~PARK_OH);
          end else if (w_pv) begin
            r_state   <= ARB_TURN;
            GNT       <= '0;
            ADE       <= 1'b0;
            r_win     <= w_pw;
            r_to_park <= 1'b0;
            r_cnt     <= '0;
          end
        end
        ARB_TURN: begin
          if (r_to_park) begin
            r_state <= ARB_PARK;
            GNT     <= PARK_OH;
            GNT_ID  <= PARK_W;
          end else begin
            r_state  <= ARB_GRANT;
            GNT      <= w_win_mask;
            GNT_ID   <= r_win;
            ADE      <= (r_win != PARK_W);
            BUS_BUSY <= 1'b1;
            r_cnt    <= 8'd1;
            r_ptr    <= w_win_inc;
            TIMEOUT  <= (MAXH == 8'd1) && |(REQ & ~w_win_mask);
          end
        end
        ARB_GRANT: begin
          if (w_end) begin
            BUS_BUSY <= 1'b0;
            ADE      <= 1'b0;
            r_cnt    <= '0;
            if (w_oth_any) begin
              r_state   <= ARB_TURN;
              GNT       <= '0;
              r_win     <= w_pw;
              r_to_park <= 1'b0;
            end else if (GNT_ID == PARK_W) begin
              r_state <= ARB_PARK;
              GNT     <= PARK_OH;
            end else begin
              // DMA driver must release before the CPU parks
              r_state   <= ARB_TURN;
              GNT       <= '0;
              r_win     <= PARK_W;
              r_to_park <= 1'b1;
            end
          end else begin
            r_cnt   <= w_cnt_nxt;
            TIMEOUT <= (w_cnt_nxt == MAXH) && w_oth_any;
          end
        end
        default: r_state <= ARB_PARK;
      endcase
    end
  end

  a_gnt_onehot0: assert property (
    @(posedge CLK) disable iff (RST) $onehot0(GNT)
  );

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench: each driven cycle queues the outputs
// expected after the next edge; a monitor pops and checks.
module tb_bus_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] REQ = '0;
  logic [2:0] DONE = '0;
  logic [2:0] GNT;
  logic [1:0] GNT_ID;
  logic       ADE;
  logic       BUS_BUSY;
  logic       TIMEOUT;

  typedef struct {
    int         step;
    logic [2:0] gnt;
    logic [1:0] id;
    logic       ade;
    logic       busy;
    logic       to;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   n_tot = 0;
  int   n_bad = 0;
  int   n_step = 0;

  bus_arbiter #(
    .N_REQ    (3),
    .PARK_ID  (0),
    .MAX_HOLD (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ      (REQ),
    .DONE     (DONE),
    .GNT      (GNT),
    .GNT_ID   (GNT_ID),
    .ADE      (ADE),
    .BUS_BUSY (BUS_BUSY),
    .TIMEOUT  (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic rst,
                     input logic [2:0] req,
                     input logic [2:0] done,
                     input logic [2:0] gnt,
                     input logic [1:0] id,
                     input logic ade,
                     input logic busy,
                     input logic to);
    exp_t e;
    @(negedge CLK);
    RST  = rst;
    REQ  = req;
    DONE = done;
    e.step = n_step;
    e.gnt  = gnt;
    e.id   = id;
    e.ade  = ade;
    e.busy = busy;
    e.to   = to;
    q.push_back(e);
    n_step++;
  endtask

  always @(posedge CLK) begin
    #1;
    if (q.size() > 0) begin
      e_mon = q.pop_front();
      chk($sformatf("s%0d.gnt", e_mon.step),
          {5'd0, GNT}, {5'd0, e_mon.gnt});
      chk($sformatf("s%0d.id", e_mon.step),
          {6'd0, GNT_ID}, {6'd0, e_mon.id});
      chk($sformatf("s%0d.ade", e_mon.step),
          {7'd0, ADE}, {7'd0, e_mon.ade});
      chk($sformatf("s%0d.busy", e_mon.step),
          {7'd0, BUS_BUSY}, {7'd0, e_mon.busy});
      chk($sformatf("s%0d.to", e_mon.step),
          {7'd0, TIMEOUT}, {7'd0, e_mon.to});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    cyc(1, 3'b000, 3'b000, 3'b001, 0, 0, 0, 0);
    cyc(1, 3'b000, 3'b000, 3'b001, 0, 0, 0, 0);
    // single DMA1 request, DONE on cycle 4
    cyc(0, 3'b010, 3'b000, 3'b000, 0, 0, 0, 0);
    cyc(0, 3'b010, 3'b000, 3'b010, 1, 1, 1, 0);
    cyc(0, 3'b010, 3'b000, 3'b010, 1, 1, 1, 0);
    cyc(0, 3'b010, 3'b000, 3'b010, 1, 1, 1, 0);
    cyc(0, 3'b010, 3'b010, 3'b000, 1, 0, 0, 0);
    cyc(0, 3'b000, 3'b000, 3'b001, 0, 0, 0, 0);
    // reset restores pointer to 1
    cyc(1, 3'b000, 3'b000, 3'b001, 0, 0, 0, 0);
    // round robin 010,100,010
    cyc(0, 3'b110, 3'b000, 3'b000, 0, 0, 0, 0);
    cyc(0, 3'b110, 3'b000, 3'b010, 1, 1, 1, 0);
    cyc(0, 3'b110, 3'b010, 3'b000, 1, 0, 0, 0);
    cyc(0, 3'b110, 3'b000, 3'b100, 2, 1, 1, 0);
    cyc(0, 3'b110, 3'b100, 3'b000, 2, 0, 0, 0);
    cyc(0, 3'b110, 3'b000, 3'b010, 1, 1, 1, 0);
    cyc(0, 3'b000, 3'b010, 3'b000, 1, 0, 0, 0);
    cyc(0, 3'b000, 3'b000, 3'b001, 0, 0, 0, 0);
    // timeout: DMA1 holds while DMA2 waits
    cyc(0, 3'b010, 3'b000, 3'b000, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++)
      cyc(0, 3'b110, 3'b000, 3'b010, 1, 1, 1, k == 8);
    cyc(0, 3'b110, 3'b000, 3'b000, 1, 0, 0, 0);
    cyc(0, 3'b110, 3'b000, 3'b100, 2, 1, 1, 0);
    cyc(0, 3'b010, 3'b100, 3'b000, 2, 0, 0, 0);
    // saturated hold with nothing pending keeps the grant
    cyc(0, 3'b010, 3'b000, 3'b010, 1, 1, 1, 0);
    for (int k = 0; k < 10; k++)
      cyc(0, 3'b010, 3'b000, 3'b010, 1, 1, 1, 0);
    cyc(0, 3'b110, 3'b000, 3'b010, 1, 1, 1, 1);
    cyc(0, 3'b110, 3'b000, 3'b000, 1, 0, 0, 0);
    cyc(0, 3'b100, 3'b000, 3'b100, 2, 1, 1, 0);
    cyc(0, 3'b000, 3'b000, 3'b000, 2, 0, 0, 0);
    cyc(0, 3'b000, 3'b000, 3'b001, 0, 0, 0, 0);
    // parked CPU, stray DONEs ignored
    cyc(0, 3'b000, 3'b110, 3'b001, 0, 0, 0, 0);
    cyc(0, 3'b001, 3'b000, 3'b001, 0, 0, 1, 0);
    cyc(0, 3'b001, 3'b010, 3'b001, 0, 0, 1, 0);
    cyc(0, 3'b001, 3'b000, 3'b001, 0, 0, 1, 0);
    cyc(0, 3'b001, 3'b001, 3'b001, 0, 0, 0, 0);
    cyc(0, 3'b000, 3'b000, 3'b001, 0, 0, 0, 0);
    // reset mid DMA2 grant, DONE in TURN ignored
    cyc(0, 3'b100, 3'b000, 3'b000, 0, 0, 0, 0);
    cyc(0, 3'b100, 3'b100, 3'b100, 2, 1, 1, 0);
    cyc(1, 3'b100, 3'b000, 3'b001, 0, 0, 0, 0);
    // reset mid DMA1 grant, pointer back to 1
    cyc(0, 3'b010, 3'b000, 3'b000, 0, 0, 0, 0);
    cyc(0, 3'b010, 3'b000, 3'b010, 1, 1, 1, 0);
    cyc(1, 3'b010, 3'b000, 3'b001, 0, 0, 0, 0);
    cyc(0, 3'b110, 3'b000, 3'b000, 0, 0, 0, 0);
    cyc(0, 3'b110, 3'b000, 3'b010, 1, 1, 1, 0);
    // withdrawal acts like DONE
    cyc(0, 3'b100, 3'b000, 3'b000, 1, 0, 0, 0);
    cyc(0, 3'b100, 3'b000, 3'b100, 2, 1, 1, 0);
    cyc(0, 3'b000, 3'b000, 3'b000, 2, 0, 0, 0);
    cyc(0, 3'b000, 3'b000, 3'b001, 0, 0, 0, 0);
    repeat (3) @(negedge CLK);
    if (q.size() != 0) begin
      n_tot++;
      n_bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
